// File: rtl/single_rocket_mover_if.sv
// Bundle between the rockets controller and one rocket slot mover.
// The controller drives launch parameters; the mover reports position and status.
interface single_rocket_mover_if;
  logic               startOfFrame;
  logic               isActive;
  logic signed [10:0] initialSpeed;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               rocketVisible;
  logic               reachedBorder;

  modport master (
    output startOfFrame, isActive, initialSpeed, initialX, initialY,
    input  topLeftX, topLeftY, rocketVisible, reachedBorder
  );

  modport slave (
    input  startOfFrame, isActive, initialSpeed, initialX, initialY,
    output topLeftX, topLeftY, rocketVisible, reachedBorder
  );
endinterface

// File: rtl/single_rocket_mover.sv
// Flies one rocket vertically in 1/64-pixel fixed point, one step per frame,
// from launch on the rising edge of isActive until it leaves the playfield.
module single_rocket_mover #(
  parameter int FP_SHIFT      = 6,
  parameter int TOP_BORDER    = 0,
  parameter int BOTTOM_BORDER = 479,
  parameter int ROCKET_HEIGHT = 16
) (
  input logic                  clk,
  input logic                  resetN,
  single_rocket_mover_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FLYING = 2'd1;
  localparam logic [1:0] EXITED = 2'd2;

  logic [1:0]         state;
  logic               is_active_d;
  logic signed [10:0] x;
  logic signed [10:0] speed;
  logic signed [17:0] y_fp;

  logic               rise;
  logic signed [17:0] next_y_fp;
  logic signed [17:0] new_y;
  logic               out_of_bounds;

  assign rise      = bus.isActive & ~is_active_d;
  // Plain 18-bit wrap-around add; callers keep launch values in range.
  assign next_y_fp = y_fp + {{7{speed[10]}}, speed};
  assign new_y     = next_y_fp >>> FP_SHIFT;
  assign out_of_bounds = (int'(new_y) < TOP_BORDER) ||
                         (int'(new_y) + ROCKET_HEIGHT > BOTTOM_BORDER + 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      is_active_d <= 1'b0;
      x           <= '0;
      speed       <= '0;
      y_fp        <= '0;
    end else begin
      is_active_d <= bus.isActive;
      case (state)
        IDLE: begin
          if (rise) begin
            x     <= bus.initialX;
            speed <= bus.initialSpeed;
            y_fp  <= {{7{bus.initialY[10]}}, bus.initialY} <<< FP_SHIFT;
            state <= FLYING;
          end
        end
        FLYING: begin
          // A cleared slot outranks both motion and a simultaneous exit.
          if (!bus.isActive) begin
            state <= IDLE;
          end else if (bus.startOfFrame) begin
            y_fp <= next_y_fp;
            if (out_of_bounds) state <= EXITED;
          end
        end
        EXITED: begin
          if (!bus.isActive) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.topLeftX      = x;
  assign bus.topLeftY      = 11'(y_fp >>> FP_SHIFT);
  assign bus.rocketVisible = (state == FLYING);
  assign bus.reachedBorder = (state == EXITED);

endmodule

// File: tb/tb_single_rocket_mover.sv
// Randomised and directed bench for single_rocket_mover; a frame-level rocket
// model feeds a scoreboard that a separate monitor drains every clock.
module tb_single_rocket_mover;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  single_rocket_mover_if bus ();

  single_rocket_mover dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    bit vis;
    bit rb;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Current values presented on the launch inputs.
  int cur_x, cur_y, cur_speed;

  // Reference model: rocket kinematics in plain integers.
  bit m_flying, m_exited, m_prev_act;
  int m_x, m_yfp, m_speed;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_flying = 0; m_exited = 0; m_prev_act = 0;
    m_x = 0; m_yfp = 0; m_speed = 0;
  endfunction

  function automatic void model_cycle(input bit sof, input bit act);
    int pix;
    if (!m_flying && !m_exited) begin
      if (act && !m_prev_act) begin
        m_x = cur_x; m_yfp = cur_y * 64; m_speed = cur_speed;
        m_flying = 1;
      end
    end else if (m_flying) begin
      if (!act) m_flying = 0;
      else if (sof) begin
        m_yfp = m_yfp + m_speed;
        pix = m_yfp >>> 6;
        if (pix < 0 || pix + 16 > 480) begin
          m_flying = 0; m_exited = 1;
        end
      end
    end else if (!act) begin
      m_exited = 0;
    end
    m_prev_act = act;
  endfunction

  task automatic step(input bit sof, input bit act);
    exp_t e;
    @(negedge clk);
    bus.startOfFrame = sof;
    bus.isActive     = act;
    bus.initialSpeed = 11'(cur_speed);
    bus.initialX     = 11'(cur_x);
    bus.initialY     = 11'(cur_y);
    model_cycle(sof, act);
    e.x = m_x; e.y = m_yfp >>> 6; e.vis = m_flying; e.rb = m_exited;
    q.push_back(e);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end
  endtask

  // Directed spot check of the result of the most recent step.
  task automatic spot(input string name, input int y, input bit vis, input bit rb);
    @(posedge clk);
    #2;
    check({name, "_y"},   int'(bus.topLeftY), y);
    check({name, "_vis"}, int'(bus.rocketVisible), int'(vis));
    check({name, "_rb"},  int'(bus.reachedBorder), int'(rb));
  endtask

  task automatic launch(input int x, input int y, input int speed);
    cur_x = x; cur_y = y; cur_speed = speed;
    step(1'b0, 1'b1);
  endtask

  // Monitor: every clock the DUT presents a fresh position/status word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_x",   int'(bus.topLeftX), e.x);
        check("sb_y",   int'(bus.topLeftY), e.y);
        check("sb_vis", int'(bus.rocketVisible), int'(e.vis));
        check("sb_rb",  int'(bus.reachedBorder), int'(e.rb));
      end
    end
  end

  initial begin
    int len;
    resetN = 1'b0;
    cur_x = 0; cur_y = 0; cur_speed = 0;
    bus.startOfFrame = 1'b0; bus.isActive = 1'b0;
    bus.initialSpeed = '0; bus.initialX = '0; bus.initialY = '0;
    model_reset();
    #3;
    check("reset_x",   int'(bus.topLeftX), 0);
    check("reset_y",   int'(bus.topLeftY), 0);
    check("reset_vis", int'(bus.rocketVisible), 0);
    check("reset_rb",  int'(bus.reachedBorder), 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Frame pulses alone do nothing.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

    // Upward rocket, exits above the top border on frame 201.
    launch(100, 400, -128);  spot("s2_launch", 400, 1, 0);
    frames(1);               spot("s2_f1", 398, 1, 0);
    frames(199);             spot("s2_f200", 0, 1, 0);
    frames(1);               spot("s2_f201", -2, 0, 1);
    step(1'b0, 1'b0);        spot("s2_drop", -2, 0, 0);

    // Slow downward rocket, exits at Y=465 on frame 130.
    launch(50, 400, 32);     spot("s3_launch", 400, 1, 0);
    frames(2);               spot("s3_f2", 401, 1, 0);
    frames(127);             spot("s3_f129", 464, 1, 0);
    frames(1);               spot("s3_f130", 465, 0, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    spot("s3_hold", 465, 0, 1);
    step(1'b0, 1'b0);        spot("s3_drop", 465, 0, 0);

    // Mid-flight abort at Y=300.
    launch(10, 400, -64);
    frames(100);             spot("s4_y300", 300, 1, 0);
    step(1'b0, 1'b0);        spot("s4_abort", 300, 0, 0);

    // Drop coincident with a would-be exit: the drop wins.
    launch(20, 0, -64);
    step(1'b1, 1'b0);        spot("drop_vs_exit", 0, 0, 0);

    // Rise together with a frame pulse: launch only.
    cur_x = 30; cur_y = 200; cur_speed = 64;
    step(1'b1, 1'b1);        spot("s5_launch", 200, 1, 0);
    frames(1);               spot("s5_f1", 201, 1, 0);
    step(1'b0, 1'b0);

    // Launch already below the playfield: first frame exits.
    launch(0, 470, 0);
    frames(1);               spot("oob_launch", 470, 0, 1);
    step(1'b0, 1'b0);

    // Zero speed hovers.
    launch(0, 100, 0);
    frames(50);              spot("hover", 100, 1, 0);
    step(1'b0, 1'b0);

    // One-cycle isActive pulse, then relaunch right after returning to IDLE.
    launch(5, 250, -64);     spot("pulse_on", 250, 1, 0);
    step(1'b0, 1'b0);        spot("pulse_off", 250, 0, 0);
    launch(6, 260, -64);     spot("relaunch", 260, 1, 0);
    step(1'b0, 1'b0);

    // Asynchronous reset mid-flight, then a fresh flight.
    launch(100, 400, -128);
    frames(10);
    @(negedge clk);
    #1;
    resetN = 1'b0;
    bus.isActive = 1'b0; bus.startOfFrame = 1'b0;
    #1;
    check("s6_rst_x",   int'(bus.topLeftX), 0);
    check("s6_rst_y",   int'(bus.topLeftY), 0);
    check("s6_rst_vis", int'(bus.rocketVisible), 0);
    check("s6_rst_rb",  int'(bus.reachedBorder), 0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    launch(100, 400, -128);  spot("s6_launch", 400, 1, 0);
    frames(1);               spot("s6_f1", 398, 1, 0);
    frames(3);
    step(1'b0, 1'b0);

    // Random flights; launch inputs wander mid-flight to prove they are latched.
    for (int f = 0; f < 30; f++) begin
      cur_x = $urandom_range(0, 639);
      cur_y = $urandom_range(0, 500);
      cur_speed = (f % 5 == 0) ? 0 : int'($urandom_range(0, 600)) - 300;
      step($urandom_range(0, 3) == 0, 1'b1);
      len = $urandom_range(20, 400);
      for (int i = 0; i < len; i++) begin
        cur_x = $urandom_range(0, 639);
        cur_y = $urandom_range(0, 479);
        cur_speed = int'($urandom_range(0, 600)) - 300;
        step($urandom_range(0, 3) == 0, 1'b1);
      end
      repeat ($urandom_range(1, 3)) step($urandom_range(0, 1) == 1, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
